// File: rtl/test_run_ctrl_if.sv
// Dump stream between the test-run controller and its downstream sink.
// The controller (master) offers register and memory beats with valid/tag/idx/data.
// The sink (slave) accepts a beat by raising dump_ready.
interface test_run_ctrl_if #(
  parameter int AW = 10
) ();
  logic          dump_valid;
  logic          dump_ready;
  logic          dump_tag;
  logic [AW-1:0] dump_idx;
  logic [31:0]   dump_data;

  modport master (
    output dump_valid,
    output dump_tag,
    output dump_idx,
    output dump_data,
    input  dump_ready
  );

  modport slave (
    input  dump_valid,
    input  dump_tag,
    input  dump_idx,
    input  dump_data,
    output dump_ready
  );
endinterface

// File: rtl/test_run_ctrl.sv
// Test-run controller: holds the CPU in reset, lets it run for a bounded
// number of cycles, then streams the register file and a window of data
// memory out over the dump interface.
// Optional macro TEST_RUN_CTRL_HALT_DETECT_EN adds self-loop detection
// (the pc repeating on consecutive RUN cycles ends the run early).
module test_run_ctrl #(
  parameter int MAX_CYCLES   = 30,
  parameter int RESET_CYCLES = 2,
  parameter int NREGS        = 32,
  parameter int DUMP_BASE    = 20,
  parameter int DUMP_WORDS   = 2,
  parameter int AW           = 10,
  parameter int CW           = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [31:0]            pc,
  input  logic [31:0]            rf_rdata,
  input  logic [31:0]            dm_rdata,
  output logic                   cpu_rst,
  output logic                   cpu_run,
  output logic [4:0]             rf_raddr,
  output logic [AW-1:0]          dm_raddr,
  test_run_ctrl_if.master        dump,
  output logic                   done,
  output logic [1:0]             halt_reason,
  output logic [CW-1:0]          cycle_cnt
);

  localparam int RCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RCW-1:0] RC_LAST   = RCW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0]  MAX_C     = CW'(MAX_CYCLES);
  localparam logic [AW-1:0]  LAST_REG  = AW'(NREGS - 1);
  localparam logic [AW-1:0]  LAST_MEM  = AW'((DUMP_WORDS > 0) ? DUMP_WORDS - 1 : 0);
  localparam logic [AW-1:0]  BASE_A    = AW'(DUMP_BASE);

  typedef enum logic [2:0] {IDLE, CRST, RUN, DREG, DMEM, DONE} state_t;

  state_t          state_reg;
  logic [RCW-1:0]  rst_cnt_reg;
  logic            cpu_rst_reg;
  logic            cpu_run_reg;
  logic [4:0]      rf_raddr_reg;
  logic [AW-1:0]   dm_raddr_reg;
  logic            dump_valid_reg;
  logic            dump_tag_reg;
  logic [AW-1:0]   dump_idx_reg;
  logic            done_reg;
  logic [1:0]      halt_reg;
  logic [CW-1:0]   cnt_reg;

  logic [CW-1:0]   cnt_next;
  logic [AW-1:0]   idx_next;
  logic            max_hit;
  logic            loop_hit;
  logic            xfer;
  logic [31:0]     dump_data_c;

  assign cnt_next = cnt_reg + 1'b1;
  assign idx_next = dump_idx_reg + 1'b1;
  // The cycle being counted now is the MAX_CYCLES-th one.
  assign max_hit  = (cnt_next == MAX_C);
  assign xfer     = dump_valid_reg & dump.dump_ready;

`ifdef TEST_RUN_CTRL_HALT_DETECT_EN
  logic [31:0] prev_pc_reg;

  // Remember the pc of the previous RUN cycle for self-loop detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_pc_reg <= '0;
    end else if (state_reg == RUN) begin
      prev_pc_reg <= pc;
    end
  end

  // Only meaningful once at least one RUN cycle has been recorded this run.
  assign loop_hit = (cnt_reg != '0) && (pc == prev_pc_reg);
`else
  logic unused_pc;
  assign unused_pc = ^pc;
  assign loop_hit  = 1'b0;
`endif

  // Register index 0 is hardwired zero, so its beat ignores the read port.
  always_comb begin
    dump_data_c = '0;
    if (state_reg == DREG) begin
      dump_data_c = (dump_idx_reg == '0) ? 32'h0 : rf_rdata;
    end else if (state_reg == DMEM) begin
      dump_data_c = dm_rdata;
    end
  end

  // Main sequencer with registered control outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      rst_cnt_reg    <= '0;
      cpu_rst_reg    <= 1'b1;
      cpu_run_reg    <= 1'b0;
      rf_raddr_reg   <= '0;
      dm_raddr_reg   <= '0;
      dump_valid_reg <= 1'b0;
      dump_tag_reg   <= 1'b0;
      dump_idx_reg   <= '0;
      done_reg       <= 1'b0;
      halt_reg       <= '0;
      cnt_reg        <= '0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_reg   <= CRST;
            rst_cnt_reg <= '0;
            cpu_rst_reg <= 1'b1;
            cpu_run_reg <= 1'b0;
            done_reg    <= 1'b0;
            halt_reg    <= '0;
            cnt_reg     <= '0;
          end
        end
        CRST: begin
          if (rst_cnt_reg == RC_LAST) begin
            state_reg   <= RUN;
            cpu_rst_reg <= 1'b0;
            cpu_run_reg <= 1'b1;
          end else begin
            rst_cnt_reg <= rst_cnt_reg + 1'b1;
          end
        end
        RUN: begin
          cnt_reg <= cnt_next;
          if (max_hit || loop_hit) begin
            state_reg      <= DREG;
            cpu_run_reg    <= 1'b0;
            halt_reg       <= {loop_hit, max_hit};
            dump_valid_reg <= 1'b1;
            dump_tag_reg   <= 1'b0;
            dump_idx_reg   <= '0;
            rf_raddr_reg   <= '0;
          end
        end
        DREG: begin
          if (xfer) begin
            if (dump_idx_reg == LAST_REG) begin
              if (DUMP_WORDS == 0) begin
                state_reg      <= DONE;
                dump_valid_reg <= 1'b0;
                done_reg       <= 1'b1;
              end else begin
                state_reg    <= DMEM;
                dump_tag_reg <= 1'b1;
                dump_idx_reg <= '0;
                dm_raddr_reg <= BASE_A;
              end
            end else begin
              dump_idx_reg <= idx_next;
              rf_raddr_reg <= 5'(idx_next);
            end
          end
        end
        DMEM: begin
          if (xfer) begin
            if (dump_idx_reg == LAST_MEM) begin
              state_reg      <= DONE;
              dump_valid_reg <= 1'b0;
              done_reg       <= 1'b1;
            end else begin
              dump_idx_reg <= idx_next;
              dm_raddr_reg <= BASE_A + idx_next;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign cpu_rst         = cpu_rst_reg;
  assign cpu_run         = cpu_run_reg;
  assign rf_raddr        = rf_raddr_reg;
  assign dm_raddr        = dm_raddr_reg;
  assign done            = done_reg;
  assign halt_reason     = halt_reg;
  assign cycle_cnt       = cnt_reg;
  assign dump.dump_valid = dump_valid_reg;
  assign dump.dump_tag   = dump_tag_reg;
  assign dump.dump_idx   = dump_idx_reg;
  assign dump.dump_data  = dump_data_c;

endmodule

// File: tb/tb_test_run_ctrl.sv
// Bench for test_run_ctrl: two instances (default build and a
// MAX_CYCLES=1 / DUMP_WORDS=0 build), randomized pc/ready/memory contents,
// expected behaviour derived from the run/dump rules with a beat queue.
module tb_test_run_ctrl;
  localparam int AW = 10;
  localparam int CW = 16;
  localparam int NREGS = 32;
  localparam int DUMP_BASE = 20;
  localparam int RC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start;
  logic [31:0] pc;
  logic        ready;
  bit          sel;

  int total = 0;
  int bad = 0;

  logic [31:0] rf_mem [0:31];
  logic [31:0] dm_mem [0:(1<<AW)-1];

  // instance 0: defaults
  logic          start0, cpu_rst0, cpu_run0, done0;
  logic [4:0]    rf_raddr0;
  logic [AW-1:0] dm_raddr0;
  logic [1:0]    halt0;
  logic [CW-1:0] cnt0;
  logic [31:0]   rf_rdata0, dm_rdata0;
  test_run_ctrl_if #(.AW(AW)) if0 ();

  // instance 1: MAX_CYCLES=1, DUMP_WORDS=0
  logic          start1, cpu_rst1, cpu_run1, done1;
  logic [4:0]    rf_raddr1;
  logic [AW-1:0] dm_raddr1;
  logic [1:0]    halt1;
  logic [CW-1:0] cnt1;
  logic [31:0]   rf_rdata1, dm_rdata1;
  test_run_ctrl_if #(.AW(AW)) if1 ();

  assign start0 = start & ~sel;
  assign start1 = start & sel;
  assign if0.dump_ready = ready & ~sel;
  assign if1.dump_ready = ready & sel;
  assign rf_rdata0 = rf_mem[rf_raddr0];
  assign dm_rdata0 = dm_mem[dm_raddr0];
  assign rf_rdata1 = rf_mem[rf_raddr1];
  assign dm_rdata1 = dm_mem[dm_raddr1];

  test_run_ctrl #(.MAX_CYCLES(30), .RESET_CYCLES(RC), .NREGS(NREGS), .DUMP_BASE(DUMP_BASE),
                  .DUMP_WORDS(2), .AW(AW), .CW(CW)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .pc(pc), .rf_rdata(rf_rdata0), .dm_rdata(dm_rdata0),
    .cpu_rst(cpu_rst0), .cpu_run(cpu_run0), .rf_raddr(rf_raddr0), .dm_raddr(dm_raddr0),
    .dump(if0.master), .done(done0), .halt_reason(halt0), .cycle_cnt(cnt0));

  test_run_ctrl #(.MAX_CYCLES(1), .RESET_CYCLES(RC), .NREGS(NREGS), .DUMP_BASE(DUMP_BASE),
                  .DUMP_WORDS(0), .AW(AW), .CW(CW)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .pc(pc), .rf_rdata(rf_rdata1), .dm_rdata(dm_rdata1),
    .cpu_rst(cpu_rst1), .cpu_run(cpu_run1), .rf_raddr(rf_raddr1), .dm_raddr(dm_raddr1),
    .dump(if1.master), .done(done1), .halt_reason(halt1), .cycle_cnt(cnt1));

  // observed view of the instance under test
  logic          o_rst, o_run, o_done, o_valid, o_tag;
  logic [4:0]    o_rfa;
  logic [AW-1:0] o_dma, o_idx;
  logic [1:0]    o_halt;
  logic [CW-1:0] o_cnt;
  logic [31:0]   o_data;
  always_comb begin
    o_rst = cpu_rst0; o_run = cpu_run0; o_done = done0; o_valid = if0.dump_valid;
    o_tag = if0.dump_tag; o_rfa = rf_raddr0; o_dma = dm_raddr0; o_idx = if0.dump_idx;
    o_halt = halt0; o_cnt = cnt0; o_data = if0.dump_data;
    if (sel) begin
      o_rst = cpu_rst1; o_run = cpu_run1; o_done = done1; o_valid = if1.dump_valid;
      o_tag = if1.dump_tag; o_rfa = rf_raddr1; o_dma = dm_raddr1; o_idx = if1.dump_idx;
      o_halt = halt1; o_cnt = cnt1; o_data = if1.dump_data;
    end
  end

  typedef struct {
    logic        tag;
    int          idx;
    logic [31:0] data;
  } beat_t;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_ctl(input string ph, input logic e_rst, input logic e_run, input logic e_valid,
                         input logic e_done, input int e_cnt, input logic [1:0] e_halt);
    chk({ph, ".cpu_rst"}, 64'(o_rst), 64'(e_rst));
    chk({ph, ".cpu_run"}, 64'(o_run), 64'(e_run));
    chk({ph, ".dump_valid"}, 64'(o_valid), 64'(e_valid));
    chk({ph, ".done"}, 64'(o_done), 64'(e_done));
    chk({ph, ".cycle_cnt"}, 64'(o_cnt), 64'(e_cnt));
    chk({ph, ".halt_reason"}, 64'(o_halt), 64'(e_halt));
  endtask

  task automatic chk_reset_state(input string ph);
    chk_ctl(ph, 1'b1, 1'b0, 1'b0, 1'b0, 0, 2'b00);
    chk({ph, ".dump_idx"}, 64'(o_idx), 64'd0);
    chk({ph, ".dump_tag"}, 64'(o_tag), 64'd0);
    chk({ph, ".rf_raddr"}, 64'(o_rfa), 64'd0);
    chk({ph, ".dm_raddr"}, 64'(o_dma), 64'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete run on the selected instance.
  // ready_mode: 0 always ready, 1 random, 2 repeating 1-0-0-1
  // loop_at: RUN cycle from which pc sticks at 0x3060 (0 = never)
  // poke: pulse start during RUN and during the dump (must be ignored)
  // abort_at: register index during whose beat rst is pulsed (-1 = none)
  task automatic do_run(input int ready_mode, input int loop_at, input bit poke, input int abort_at);
    int mc, dw, n, t, cyc;
    logic [1:0] ehalt;
    logic [31:0] pc_seq [0:64];
    logic [31:0] base;
    beat_t q[$];
    beat_t b;
    bit lp, mh;
    int ts;
    mc = sel ? 1 : 30;
    dw = sel ? 0 : 2;
    for (int i = 0; i < 32; i++) rf_mem[i] = $urandom | 32'h1;
    for (int i = 0; i < (1 << AW); i++) dm_mem[i] = $urandom;
    base = $urandom & 32'h00FF_FFF0;
    for (int k = 1; k <= mc; k++) begin
      pc_seq[k] = base + 32'(4 * k);
      if (loop_at > 0 && k >= loop_at) pc_seq[k] = 32'h3060;
    end
    // run length and halt cause from the pc trace
    n = mc;
    ehalt = 2'b01;
    for (int k = 1; k <= mc; k++) begin
      lp = 1'b0;
`ifdef TEST_RUN_CTRL_HALT_DETECT_EN
      lp = (k >= 2) && (pc_seq[k] == pc_seq[k-1]);
`endif
      mh = (k == mc);
      if (lp || mh) begin
        n = k;
        ehalt = {lp, mh};
        break;
      end
    end
    // expected dump stream
    for (int i = 0; i < NREGS; i++) begin
      b.tag = 1'b0; b.idx = i; b.data = (i == 0) ? 32'h0 : rf_mem[i];
      q.push_back(b);
    end
    for (int j = 0; j < dw; j++) begin
      b.tag = 1'b1; b.idx = j; b.data = dm_mem[(DUMP_BASE + j) % (1 << AW)];
      q.push_back(b);
    end
    $display("run sel=%0d mode=%0d loop_at=%0d poke=%0d abort=%0d -> run_cycles=%0d halt=%b beats=%0d",
             sel, ready_mode, loop_at, poke, abort_at, n, ehalt, q.size());

    start = 1'b1;
    step();
    start = 1'b0;
    // reset hold then RUN cycles
    for (t = 1; t <= RC + n; t++) begin
      pc = (t > RC) ? pc_seq[t - RC] : $urandom;
      chk_ctl((t > RC) ? "run" : "crst", (t <= RC), (t > RC), 1'b0, 1'b0,
              (t > RC) ? (t - RC - 1) : 0, 2'b00);
      if (poke && t == RC + 1) start = 1'b1;
      step();
      start = 1'b0;
    end
    // dump beats
    cyc = 0;
    while (q.size() > 0) begin
      b = q[0];
      chk_ctl("dump", 1'b0, 1'b0, 1'b1, 1'b0, n, ehalt);
      chk("dump.tag", 64'(o_tag), 64'(b.tag));
      chk("dump.idx", 64'(o_idx), 64'(b.idx));
      chk("dump.data", 64'(o_data), 64'(b.data));
      if (b.tag) chk("dump.dm_raddr", 64'(o_dma), 64'((DUMP_BASE + b.idx) % (1 << AW)));
      else       chk("dump.rf_raddr", 64'(o_rfa), 64'(b.idx % 32));
      if (abort_at >= 0 && !b.tag && b.idx == abort_at) begin
        #2 rst = 1'b0;
        #1 chk_reset_state("abort");
        step();
        chk_reset_state("abort_held");
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
          step();
          chk_reset_state("idle_after_abort");
        end
        return;
      end
      case (ready_mode)
        0: ready = 1'b1;
        1: ready = 1'($urandom_range(0, 1));
        default: ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      endcase
      if (poke && cyc == 0) start = 1'b1;
      step();
      start = 1'b0;
      if (ready) void'(q.pop_front());
      cyc++;
      if (cyc > 600) begin
        chk("dump_timeout", 64'd1, 64'd0);
        break;
      end
    end
    ready = 1'b0;
    // DONE holds its results
    for (int i = 0; i < 3; i++) begin
      chk_ctl("done", 1'b0, 1'b0, 1'b0, 1'b1, n, ehalt);
      step();
    end
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    pc = '0;
    ready = 1'b0;
    sel = 1'b0;
    #12;
    chk_reset_state("reset");
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_reset_state("idle_no_start");
    end

    do_run(0, 0, 1'b0, -1);
    do_run(2, 0, 1'b1, -1);
    do_run(0, 5, 1'b0, -1);
    do_run(1, int'($urandom_range(2, 29)), 1'b0, -1);
    do_run(1, int'($urandom_range(2, 29)), 1'b1, -1);
    do_run(0, 0, 1'b0, 7);
    do_run(1, 0, 1'b0, -1);

    sel = 1'b1;
    step();
    do_run(0, 0, 1'b0, -1);
    do_run(1, 0, 1'b1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
